// File: rtl/toy_proc_pkg.sv
// rtl/toy_proc_pkg.sv - shared datapath constants for the ToyProcessor
package toy_proc_pkg;

    // Default datapath width of the operand/result bus
    localparam int DATA_W = 8;

endpackage

// File: rtl/zero_or_tree.sv
// rtl/zero_or_tree.sv - balanced pairwise OR-reduction tree
module zero_or_tree
    import toy_proc_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] data,
    output logic             any_set
);

    // Each level ORs adjacent pairs. An odd leftover bit is forwarded unchanged to the
    // next level, which keeps the tree depth at ceil(log2(WIDTH)).
    generate
        if (WIDTH == 1) begin : g_leaf
            assign any_set = data[0];
        end else begin : g_level
            localparam int NEXT_W = (WIDTH + 1) / 2;
            logic [NEXT_W-1:0] next_level;

            for (genvar i = 0; i < WIDTH / 2; i++) begin : g_pair
                assign next_level[i] = data[2*i] | data[2*i+1];
            end

            if ((WIDTH % 2) == 1) begin : g_odd
                assign next_level[NEXT_W-1] = data[WIDTH-1];
            end

            zero_or_tree #(.WIDTH(NEXT_W)) u_next (
                .data    (next_level),
                .any_set (any_set)
            );
        end
    endgenerate

endmodule

// File: rtl/test_zero.sv
// rtl/test_zero.sv - zero detector with registered Z flag and sticky zero-seen flag
module test_zero
    import toy_proc_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] n,
    input  logic             flag_en,
    input  logic             sticky_clr,
    output logic             is_zero,
    output logic             zero_flag,
    output logic             zero_sticky
);

    logic any_set;

    zero_or_tree #(.WIDTH(WIDTH)) u_or_tree (
        .data    (n),
        .any_set (any_set)
    );

    // Purely combinational so it can serve as the ALU Z condition, even during reset
    assign is_zero = ~any_set;

    // Z flag captures is_zero when enabled; a new zero capture beats a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_flag   <= 1'b0;
            zero_sticky <= 1'b0;
        end else begin
            if (flag_en) begin
                zero_flag <= is_zero;
            end
            if (flag_en && is_zero) begin
                zero_sticky <= 1'b1;
            end else if (sticky_clr) begin
                zero_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_test_zero.sv
// tb/tb_test_zero.sv - self-checking bench for test_zero
module tb_test_zero;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  n = 8'h00;
    logic        flag_en = 1'b0;
    logic        sticky_clr = 1'b0;
    logic        is_zero, zero_flag, zero_sticky;

    logic [0:0]  n1 = 1'b0;
    logic [6:0]  n7 = 7'h00;
    logic [31:0] n32 = 32'h0;
    logic        z1, f1, s1, z7, f7, s7, z32, f32, s32;

    int total = 0;
    int bad = 0;

    always #10 clk = ~clk;

    test_zero #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .n(n), .flag_en(flag_en), .sticky_clr(sticky_clr),
        .is_zero(is_zero), .zero_flag(zero_flag), .zero_sticky(zero_sticky)
    );

    test_zero #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .n(n1), .flag_en(1'b0), .sticky_clr(1'b0),
        .is_zero(z1), .zero_flag(f1), .zero_sticky(s1)
    );

    test_zero #(.WIDTH(7)) dut_w7 (
        .clk(clk), .rst_n(rst_n), .n(n7), .flag_en(1'b0), .sticky_clr(1'b0),
        .is_zero(z7), .zero_flag(f7), .zero_sticky(s7)
    );

    test_zero #(.WIDTH(32)) dut_w32 (
        .clk(clk), .rst_n(rst_n), .n(n32), .flag_en(1'b0), .sticky_clr(1'b0),
        .is_zero(z32), .zero_flag(f32), .zero_sticky(s32)
    );

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: last captured zero-ness, and "a zero was captured since the last clear"
    logic m_flag = 1'b0;
    logic m_sticky = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flag   = 1'b0;
            m_sticky = 1'b0;
        end else begin
            if (flag_en) m_flag = (n == 8'd0);
            if (flag_en && n == 8'd0) m_sticky = 1'b1;
            else if (sticky_clr)      m_sticky = 1'b0;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        check("model_is_zero", is_zero, n == 8'd0);
        check("model_zero_flag", zero_flag, m_flag);
        check("model_zero_sticky", zero_sticky, m_sticky);
        check("model_w1_is_zero", z1, n1 == 1'b0);
        check("model_w7_is_zero", z7, n7 == 7'd0);
        check("model_w32_is_zero", z32, n32 == 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] pats [5];

    initial begin
        pats[0] = 8'h00; pats[1] = 8'hAA; pats[2] = 8'h55; pats[3] = 8'hFF; pats[4] = 8'h00;

        // Reset state; is_zero valid while in reset
        #1;
        check("reset_flag", zero_flag, 1'b0);
        check("reset_sticky", zero_sticky, 1'b0);
        check("reset_is_zero", is_zero, 1'b1);
        n = 8'h04;
        #1;
        check("reset_is_zero_nonzero", is_zero, 1'b0);
        n = 8'h00;
        step();
        rst_n = 1'b1;

        // Walking one, 100 ns each
        for (int i = 0; i < 8; i++) begin
            n = 8'h01 << i;
            #1;
            check($sformatf("walk_%0d", i), is_zero, 1'b0);
            #99;
        end

        // Patterns tracked without a clock edge
        step();
        for (int i = 0; i < 5; i++) begin
            n = pats[i];
            #1;
            check($sformatf("pat_%02h", pats[i]), is_zero, (i == 0 || i == 4) ? 1'b1 : 1'b0);
        end
        check("pat_no_capture", zero_flag, 1'b0);

        // Flag capture
        n = 8'h00; flag_en = 1'b1;
        step();
        check("cap_zero_flag", zero_flag, 1'b1);
        check("cap_zero_sticky", zero_sticky, 1'b1);
        n = 8'h10; flag_en = 1'b0;
        step();
        check("hold_flag", zero_flag, 1'b1);
        flag_en = 1'b1;
        step();
        check("cap_nonzero_flag", zero_flag, 1'b0);
        check("sticky_kept", zero_sticky, 1'b1);

        // Sticky behaviour
        n = 8'h00;
        step();
        n = 8'h3C;
        step();
        check("sticky_after_3c", zero_sticky, 1'b1);
        check("flag_after_3c", zero_flag, 1'b0);
        flag_en = 1'b0; sticky_clr = 1'b1;
        step();
        check("sticky_cleared", zero_sticky, 1'b0);
        n = 8'h00; flag_en = 1'b1; sticky_clr = 1'b1;
        step();
        check("set_beats_clr", zero_sticky, 1'b1);
        check("set_beats_clr_flag", zero_flag, 1'b1);

        // Asynchronous reset between edges
        flag_en = 1'b0; sticky_clr = 1'b0;
        #5;
        rst_n = 1'b0;
        #1;
        check("async_rst_flag", zero_flag, 1'b0);
        check("async_rst_sticky", zero_sticky, 1'b0);
        check("rst_is_zero_0", is_zero, 1'b1);
        n = 8'h81;
        #1;
        check("rst_is_zero_81", is_zero, 1'b0);
        n = 8'h00; flag_en = 1'b1;
        step();
        check("rst_blocks_capture", zero_flag, 1'b0);
        rst_n = 1'b1;
        step();
        check("post_rst_capture", zero_flag, 1'b1);
        check("post_rst_sticky", zero_sticky, 1'b1);
        flag_en = 1'b0;

        // Width sweep
        n1 = 1'b0; n7 = 7'h00; n32 = 32'h0;
        #1;
        check("w1_zero", z1, 1'b1);
        check("w7_zero", z7, 1'b1);
        check("w32_zero", z32, 1'b1);
        n1 = 1'b1;
        #1;
        check("w1_bit0", z1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            n7 = 7'h01 << i;
            #1;
            check($sformatf("w7_bit%0d", i), z7, 1'b0);
        end
        for (int i = 0; i < 32; i++) begin
            n32 = 32'h1 << i;
            #1;
            check($sformatf("w32_bit%0d", i), z32, 1'b0);
        end
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
